// File: rtl/bus_interface_ir_queue_pkg.sv
// Shared register offsets and bit positions for the IR transmitter command queue.
package bus_interface_ir_queue_pkg;

  localparam logic [7:0] RegCmd  = 8'd0;
  localparam logic [7:0] RegCtrl = 8'd1;

  localparam int unsigned CtrlFlushBit  = 0;
  localparam int unsigned CtrlClrOvfBit = 7;

  localparam int unsigned StatusOvfBit   = 7;
  localparam int unsigned StatusFullBit  = 6;
  localparam int unsigned StatusEmptyBit = 5;
  localparam int unsigned StatusCountW   = 5;

  function automatic logic [7:0] pack_status(input logic ovf, input logic full,
                                             input logic empty,
                                             input logic [StatusCountW-1:0] count);
    logic [7:0] s;
    s = 8'h00;
    s[StatusCountW-1:0] = count;
    s[StatusEmptyBit]   = empty;
    s[StatusFullBit]    = full;
    s[StatusOvfBit]     = ovf;
    return s;
  endfunction

endpackage

// File: rtl/ir_cmd_fifo.sv
// First-word-fall-through command FIFO with flush; storage is intentionally not reset.
module ir_cmd_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [PtrW-1:0] PtrOne = 1;
  localparam logic [CntW-1:0] CntOne = 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  push_ok, pop_ok;

  assign full  = (cnt_q == CntFull);
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign rdata = mem[rptr_q];

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign pop_ok   = pop && !empty && !flush;
  assign push_ok  = push && !flush && (!full || pop_ok);
  assign overflow = push && !flush && full && !pop_ok;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PtrOne;
      if (pop_ok)  rptr_d = rptr_q + PtrOne;
      if (push_ok && !pop_ok) begin
        cnt_d = cnt_q + CntOne;
      end else if (!push_ok && pop_ok) begin
        cnt_d = cnt_q - CntOne;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/bus_interface_ir_queue.sv
// Memory-mapped command queue for the IR transmitter: CMD push/LAST, CTRL flush/OVF clear,
// registered status readback.
module bus_interface_ir_queue
  import bus_interface_ir_queue_pkg::*;
#(
  parameter logic [7:0]  IO_ADDRESS = 8'h90,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  BUS_WE,
  input  logic [7:0]            BUS_ADDR,
  input  logic [DATA_WIDTH-1:0] BUS_DATA_IN,
  output logic [DATA_WIDTH-1:0] BUS_DATA_OUT,
  output logic                  BUS_DATA_OUT_EN,
  output logic [DATA_WIDTH-1:0] CMD_DATA,
  output logic                  CMD_VALID,
  input  logic                  CMD_READY
);

  localparam logic [7:0] CmdAddr  = IO_ADDRESS + RegCmd;
  localparam logic [7:0] CtrlAddr = IO_ADDRESS + RegCtrl;

  logic                  cmd_sel, ctrl_sel, rd_sel;
  logic                  cmd_wr, ctrl_wr, flush, clr_ovf, pop;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  fifo_full, fifo_empty, fifo_overflow;
  logic [DATA_WIDTH-1:0] status;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_en_q;

  assign cmd_sel  = (BUS_ADDR == CmdAddr);
  assign ctrl_sel = (BUS_ADDR == CtrlAddr);
  assign cmd_wr   = BUS_WE && cmd_sel;
  assign ctrl_wr  = BUS_WE && ctrl_sel;
  assign rd_sel   = !BUS_WE && (cmd_sel || ctrl_sel);
  assign flush    = ctrl_wr && BUS_DATA_IN[CtrlFlushBit];
  assign clr_ovf  = ctrl_wr && BUS_DATA_IN[CtrlClrOvfBit];
  assign pop      = CMD_VALID && CMD_READY;

  ir_cmd_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .push     (cmd_wr),
    .pop      (pop),
    .flush    (flush),
    .wdata    (BUS_DATA_IN),
    .rdata    (CMD_DATA),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (fifo_overflow)
  );

  assign CMD_VALID = !fifo_empty;

  always_comb begin
    status      = '0;
    status[7:0] = pack_status(ovf_q, fifo_full, fifo_empty, StatusCountW'(fifo_count));
  end

  always_comb begin
    last_d = cmd_wr ? BUS_DATA_IN : last_q;
    ovf_d  = ovf_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end else if (fifo_overflow) begin
      ovf_d = 1'b1;
    end
  end

  // Status is sampled before this cycle's push/pop takes effect.
  always_comb begin
    rd_data_d = '0;
    if (rd_sel) rd_data_d = ctrl_sel ? status : last_q;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      last_q    <= '0;
      ovf_q     <= 1'b0;
      rd_data_q <= '0;
      rd_en_q   <= 1'b0;
    end else begin
      last_q    <= last_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      rd_en_q   <= rd_sel;
    end
  end

  assign BUS_DATA_OUT    = rd_data_q;
  assign BUS_DATA_OUT_EN = rd_en_q;

endmodule

// File: tb/tb_bus_interface_ir_queue.sv
// Directed plus random bench for bus_interface_ir_queue against a queue-based reference model.
module tb_bus_interface_ir_queue;

  localparam int unsigned DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       BUS_WE;
  logic [7:0] BUS_ADDR;
  logic [7:0] BUS_DATA_IN;
  logic [7:0] BUS_DATA_OUT;
  logic       BUS_DATA_OUT_EN;
  logic [7:0] CMD_DATA;
  logic       CMD_VALID;
  logic       CMD_READY;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [7:0] mq[$];
  logic [7:0] m_last;
  logic       m_ovf;

  always #5 CLK = ~CLK;

  bus_interface_ir_queue #(
    .IO_ADDRESS (8'h90),
    .DATA_WIDTH (8),
    .DEPTH      (DEPTH)
  ) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .BUS_WE          (BUS_WE),
    .BUS_ADDR        (BUS_ADDR),
    .BUS_DATA_IN     (BUS_DATA_IN),
    .BUS_DATA_OUT    (BUS_DATA_OUT),
    .BUS_DATA_OUT_EN (BUS_DATA_OUT_EN),
    .CMD_DATA        (CMD_DATA),
    .CMD_VALID       (CMD_VALID),
    .CMD_READY       (CMD_READY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_status();
    int unsigned sz;
    sz = mq.size();
    return 8'((m_ovf ? 128 : 0) + (sz == DEPTH ? 64 : 0) + (sz == 0 ? 32 : 0) + sz);
  endfunction

  // Apply the currently driven inputs to the model, clock once, then compare.
  task automatic tick();
    logic       do_pop, exp_en;
    logic [7:0] exp_data, st;
    st       = model_status();
    do_pop   = (mq.size() != 0) && CMD_READY;
    exp_en   = !BUS_WE && (BUS_ADDR == 8'h90 || BUS_ADDR == 8'h91);
    exp_data = !exp_en ? 8'h00 : (BUS_ADDR == 8'h90 ? m_last : st);
    if (do_pop) void'(mq.pop_front());
    if (BUS_WE && BUS_ADDR == 8'h90) begin
      m_last = BUS_DATA_IN;
      if (mq.size() < DEPTH) mq.push_back(BUS_DATA_IN);
      else m_ovf = 1'b1;
    end
    if (BUS_WE && BUS_ADDR == 8'h91) begin
      if (BUS_DATA_IN[0]) mq.delete();
      if (BUS_DATA_IN[7]) m_ovf = 1'b0;
    end
    @(posedge CLK);
    #1;
    chk("cmd_valid", 32'(CMD_VALID), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("cmd_data", 32'(CMD_DATA), 32'(mq[0]));
    chk("rd_en", 32'(BUS_DATA_OUT_EN), 32'(exp_en));
    chk("rd_data", 32'(BUS_DATA_OUT), 32'(exp_data));
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic rdy);
    BUS_WE = 1'b1; BUS_ADDR = a; BUS_DATA_IN = d; CMD_READY = rdy;
    tick();
  endtask

  task automatic rd(input logic [7:0] a, input logic rdy);
    BUS_WE = 1'b0; BUS_ADDR = a; BUS_DATA_IN = 8'h00; CMD_READY = rdy;
    tick();
  endtask

  task automatic idle(input logic rdy);
    BUS_WE = 1'b0; BUS_ADDR = 8'h00; BUS_DATA_IN = 8'h00; CMD_READY = rdy;
    tick();
  endtask

  initial begin
    RESET_N = 1'b0; BUS_WE = 1'b0; BUS_ADDR = 8'h00; BUS_DATA_IN = 8'h00; CMD_READY = 1'b0;
    mq.delete(); m_last = 8'h00; m_ovf = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_valid", 32'(CMD_VALID), 32'(0));
    chk("reset_out_en", 32'(BUS_DATA_OUT_EN), 32'(0));
    chk("reset_out", 32'(BUS_DATA_OUT), 32'(0));
    RESET_N = 1'b1;

    // Reset readback; OUT_EN is a one-cycle pulse.
    rd(8'h91, 1'b0);
    chk("status_after_reset", 32'(BUS_DATA_OUT), 32'h20);
    idle(1'b0);
    chk("out_en_one_cycle", 32'(BUS_DATA_OUT_EN), 32'(0));
    rd(8'h90, 1'b0);
    chk("last_after_reset", 32'(BUS_DATA_OUT), 32'h00);

    // Three pushes, then drain in order.
    wr(8'h90, 8'hA1, 1'b0);
    wr(8'h90, 8'hB2, 1'b0);
    wr(8'h90, 8'hC3, 1'b0);
    rd(8'h91, 1'b0);
    chk("status_three", 32'(BUS_DATA_OUT), 32'h03);
    chk("head_a1", 32'(CMD_DATA), 32'hA1);
    repeat (3) idle(1'b1);
    chk("drained_valid", 32'(CMD_VALID), 32'(0));

    // Overflow on the fifth write; OVF is sticky until cleared.
    for (int i = 0; i < 5; i++) wr(8'h90, 8'(8'h11 + i), 1'b0);
    rd(8'h91, 1'b0);
    chk("status_ovf_full", 32'(BUS_DATA_OUT), 32'hC4);
    rd(8'h90, 1'b0);
    chk("last_0x15", 32'(BUS_DATA_OUT), 32'h15);
    repeat (4) idle(1'b1);
    wr(8'h91, 8'h80, 1'b0);
    rd(8'h91, 1'b0);
    chk("ovf_cleared", 32'(BUS_DATA_OUT), 32'h20);

    // Push into a full queue while popping is accepted.
    for (int i = 0; i < 4; i++) wr(8'h90, 8'(8'h21 + i), 1'b0);
    wr(8'h90, 8'h77, 1'b1);
    rd(8'h91, 1'b0);
    chk("full_push_pop", 32'(BUS_DATA_OUT), 32'h44);
    repeat (3) idle(1'b1);
    chk("head_77_fourth", 32'(CMD_DATA), 32'h77);
    idle(1'b1);

    // Flush with two entries queued; OVF untouched by bit0 alone.
    wr(8'h90, 8'h31, 1'b0);
    wr(8'h90, 8'h32, 1'b0);
    wr(8'h91, 8'h01, 1'b0);
    rd(8'h91, 1'b0);
    chk("status_after_flush", 32'(BUS_DATA_OUT), 32'h20);

    // Pointer wrap with back-to-back push/pop.
    for (int i = 0; i < 10; i++) wr(8'h90, 8'($urandom), 1'b1);
    repeat (2) idle(1'b1);

    // Random traffic, including out-of-window addresses and flush/clear combinations.
    for (int i = 0; i < 400; i++) begin
      int unsigned sel;
      logic [7:0]  a, d;
      sel = $urandom_range(0, 9);
      a = (sel < 4) ? 8'h90 : (sel < 7) ? 8'h91 : 8'($urandom);
      d = 8'($urandom);
      if (a == 8'h91) begin
        d[0] = ($urandom_range(0, 4) == 0);
        d[7] = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 1) == 1) wr(a, d, 1'($urandom_range(0, 2) == 0));
      else rd(a, 1'($urandom_range(0, 2) == 0));
    end

    // Asynchronous reset in the middle of a drain.
    wr(8'h91, 8'h81, 1'b0);
    for (int i = 0; i < 3; i++) wr(8'h90, 8'(8'h41 + i), 1'b0);
    rd(8'h91, 1'b1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("async_valid_drop", 32'(CMD_VALID), 32'(0));
    chk("async_out_en_drop", 32'(BUS_DATA_OUT_EN), 32'(0));
    mq.delete(); m_last = 8'h00; m_ovf = 1'b0;
    BUS_WE = 1'b0; BUS_ADDR = 8'h00; CMD_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    rd(8'h91, 1'b0);
    chk("status_after_async", 32'(BUS_DATA_OUT), 32'h20);
    rd(8'h90, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
